// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl
//  Description : Instruction-cache line refill controller. Writes one cache
//                line (2^LINE_WORDS_W words, word 0 first) from the memory
//                beat stream into the data RAM. CPU reads share the single
//                RAM port; refill writes win. A CPU read to the line being
//                filled is granted only once its word has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl #(
    parameter int LINE_WORDS_W = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,          // active-low, asynchronous
    // CPU fetch port
    input  logic                     cpu_rd_i,
    input  logic [9:0]               cpu_addr_i,
    output logic                     cpu_grant_o,
    // refill request
    input  logic                     refill_req_i,
    input  logic [9-LINE_WORDS_W:0]  refill_line_i,
    output logic                     refill_busy_o,
    output logic                     refill_done_o,
    // memory beat stream
    input  logic                     mem_valid_i,
    input  logic [31:0]              mem_data_i,
    output logic                     mem_ready_o,
    // data RAM port
    output logic [9:0]               ram_addr_o,
    output logic [31:0]              ram_data_o,
    output logic                     ram_wr_o
);

    localparam int c_WORDS  = 1 << LINE_WORDS_W;
    localparam int c_LINE_W = 10 - LINE_WORDS_W;
    localparam logic [LINE_WORDS_W-1:0] c_LAST_WORD = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_LINE_W-1:0]     r_line;
    logic [LINE_WORDS_W-1:0] r_count;
    logic [c_WORDS-1:0]      r_mask;

    logic                    w_fill;
    logic                    w_beat;
    logic [c_LINE_W-1:0]     w_cpu_line;
    logic [LINE_WORDS_W-1:0] w_cpu_word;
    logic                    w_rd_safe;

    assign w_fill     = (r_state == FILL);
    assign w_beat     = w_fill & mem_valid_i;
    assign w_cpu_line = cpu_addr_i[9:LINE_WORDS_W];
    assign w_cpu_word = cpu_addr_i[LINE_WORDS_W-1:0];

    // A CPU read is safe unless it targets a not-yet-written word of the line in flight
    assign w_rd_safe  = !w_fill || (w_cpu_line != r_line) || r_mask[w_cpu_word];

    // RAM port steering: a refill beat owns the port, otherwise the CPU address passes through
    always_comb begin
        ram_wr_o    = w_beat;
        ram_addr_o  = w_beat ? {r_line, r_count} : cpu_addr_i;
        ram_data_o  = w_beat ? mem_data_i : 32'h0;
        // rst_i gating keeps the grant low while reset is held, whatever cpu_rd_i does
        cpu_grant_o = rst_i & cpu_rd_i & ~w_beat & w_rd_safe;
    end

    assign mem_ready_o   = w_fill;
    assign refill_busy_o = w_fill;
    assign refill_done_o = (r_state == DONE);

    // Refill sequencing: accept in IDLE, count beats in FILL, one-cycle DONE pulse
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_count <= '0;
            r_mask  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (refill_req_i) begin
                        r_line  <= refill_line_i;
                        r_count <= '0;
                        r_mask  <= '0;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_valid_i) begin
                        r_mask[r_count] <= 1'b1;
                        r_count         <= r_count + 1'b1;   // wraps to 0 after the last word
                        if (r_count == c_LAST_WORD) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_ctrl
//  Description : Directed bench for icache_refill_ctrl. Stimulus pushes the
//                expected RAM-port event for each cycle where one should
//                occur; a monitor pops and compares whenever the DUT writes,
//                grants or signals done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_rd_i;
    logic [9:0]  cpu_addr_i;
    logic        cpu_grant_o;
    logic        refill_req_i;
    logic [6:0]  refill_line_i;
    logic        refill_busy_o;
    logic        refill_done_o;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic        mem_ready_o;
    logic [9:0]  ram_addr_o;
    logic [31:0] ram_data_o;
    logic        ram_wr_o;

    // event record: {wr, grant, done, addr[9:0], data[31:0]}
    logic [44:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    icache_refill_ctrl #(.LINE_WORDS_W(3)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cpu_rd_i      (cpu_rd_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_grant_o   (cpu_grant_o),
        .refill_req_i  (refill_req_i),
        .refill_line_i (refill_line_i),
        .refill_busy_o (refill_busy_o),
        .refill_done_o (refill_done_o),
        .mem_valid_i   (mem_valid_i),
        .mem_data_i    (mem_data_i),
        .mem_ready_o   (mem_ready_o),
        .ram_addr_o    (ram_addr_o),
        .ram_data_o    (ram_data_o),
        .ram_wr_o      (ram_wr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every visible RAM-port event must match the next expected record
    always @(negedge clk_i) begin
        logic [44:0] act;
        logic [44:0] e;
        if (ram_wr_o || cpu_grant_o || refill_done_o) begin
            act = {ram_wr_o, cpu_grant_o, refill_done_o, ram_addr_o,
                   (ram_wr_o ? ram_data_o : 32'h0)};
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event t=%0t act wr/gr/dn/addr/data=%b%b%b/%h/%h",
                         $time, act[44], act[43], act[42], act[41:32], act[31:0]);
            end else begin
                e = exp_q.pop_front();
                if (act === e) n_pass++;
                else $display("FAIL event t=%0t act=%b%b%b/%h/%h exp=%b%b%b/%h/%h",
                              $time, act[44], act[43], act[42], act[41:32], act[31:0],
                              e[44], e[43], e[42], e[41:32], e[31:0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    endtask

    task automatic push_ev(input logic wr, input logic gr, input logic dn,
                           input logic [9:0] addr, input logic [31:0] data);
        exp_q.push_back({wr, gr, dn, addr, data});
    endtask

    // One cycle: drive inputs just after posedge, check busy/ready at negedge
    task automatic step(input logic rd, input logic [9:0] addr, input logic req,
                        input logic [6:0] line, input logic mv, input logic [31:0] md,
                        input logic busy_exp, input string tag);
        cpu_rd_i      = rd;
        cpu_addr_i    = addr;
        refill_req_i  = req;
        refill_line_i = line;
        mem_valid_i   = mv;
        mem_data_i    = md;
        @(negedge clk_i);
        check({tag, "_busy"},  32'(refill_busy_o), 32'(busy_exp));
        check({tag, "_ready"}, 32'(mem_ready_o),   32'(busy_exp));
        @(posedge clk_i);
        #1;
    endtask

    task automatic accept(input logic [6:0] line);
        step(1'b0, 10'h0, 1'b1, line, 1'b0, 32'h0, 1'b0, "accept");
    endtask

    task automatic beat(input logic [6:0] line, input logic [2:0] w, input logic [31:0] d);
        push_ev(1'b1, 1'b0, 1'b0, {line, w}, d);
        step(1'b0, 10'h0, 1'b0, 7'h0, 1'b1, d, 1'b1, "beat");
    endtask

    task automatic done_cycle(input logic req, input logic [6:0] line);
        push_ev(1'b0, 1'b0, 1'b1, 10'h0, 32'h0);
        step(1'b0, 10'h0, req, line, 1'b0, 32'h0, 1'b0, "done");
    endtask

    initial begin
        // ---- reset state, with busy inputs driven ----
        rst_i = 1'b0; cpu_rd_i = 1'b1; cpu_addr_i = 10'h155;
        refill_req_i = 1'b1; refill_line_i = 7'h11; mem_valid_i = 1'b1; mem_data_i = 32'hDEAD;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_grant", 32'(cpu_grant_o),   32'h0);
        check("rst_wr",    32'(ram_wr_o),      32'h0);
        check("rst_busy",  32'(refill_busy_o), 32'h0);
        check("rst_ready", 32'(mem_ready_o),   32'h0);
        check("rst_done",  32'(refill_done_o), 32'h0);
        check("rst_addr",  32'(ram_addr_o),    32'h155);
        check("rst_data",  ram_data_o,         32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // ---- line 0x05, 8 back-to-back beats ----
        accept(7'h05);
        for (int i = 0; i < 8; i++) beat(7'h05, 3'(i), 32'hA0 + 32'(i));
        done_cycle(1'b0, 7'h00);

        // ---- CPU reads against the line in flight ----
        step(1'b0, 10'h0, 1'b0, 7'h0, 1'b1, 32'h5, 1'b0, "idle_mv");   // stray valid ignored
        accept(7'h05);
        for (int i = 0; i < 3; i++) beat(7'h05, 3'(i), 32'hB0 + 32'(i));
        push_ev(1'b0, 1'b1, 1'b0, 10'h02A, 32'h0);
        step(1'b1, 10'h02A, 1'b0, 7'h0, 1'b0, 32'h0, 1'b1, "rd_written");
        step(1'b1, 10'h02C, 1'b0, 7'h0, 1'b0, 32'h0, 1'b1, "rd_pending");
        push_ev(1'b1, 1'b0, 1'b0, 10'h02B, 32'hB3);
        step(1'b1, 10'h02C, 1'b0, 7'h0, 1'b1, 32'hB3, 1'b1, "rd_pending_b3");
        push_ev(1'b1, 1'b0, 1'b0, 10'h02C, 32'hB4);
        step(1'b1, 10'h02C, 1'b0, 7'h0, 1'b1, 32'hB4, 1'b1, "rd_landing");
        push_ev(1'b0, 1'b1, 1'b0, 10'h02C, 32'h0);
        step(1'b1, 10'h02C, 1'b0, 7'h0, 1'b0, 32'h0, 1'b1, "rd_landed");
        push_ev(1'b1, 1'b0, 1'b0, 10'h02D, 32'hB5);
        step(1'b1, 10'h100, 1'b0, 7'h0, 1'b1, 32'hB5, 1'b1, "rd_vs_beat");
        push_ev(1'b0, 1'b1, 1'b0, 10'h100, 32'h0);
        step(1'b1, 10'h100, 1'b0, 7'h0, 1'b0, 32'h0, 1'b1, "rd_after_beat");
        beat(7'h05, 3'd6, 32'hB6);
        beat(7'h05, 3'd7, 32'hB7);
        done_cycle(1'b0, 7'h00);

        // ---- line 0x12 with valid every third cycle ----
        accept(7'h12);
        for (int i = 0; i < 8; i++) begin
            beat(7'h12, 3'(i), 32'hC0 + 32'(i));
            if (i < 7) begin
                push_ev(1'b0, 1'b1, 1'b0, 10'h200 + 10'(i), 32'h0);
                step(1'b1, 10'h200 + 10'(i), 1'b0, 7'h0, 1'b0, 32'h0, 1'b1, "gap_other");
                step(1'b1, {7'h12, 3'(i + 1)}, 1'b0, 7'h0, 1'b0, 32'h0, 1'b1, "gap_same");
            end
        end
        done_cycle(1'b0, 7'h00);

        // ---- reset mid-fill, then line 0x7F ----
        accept(7'h33);
        for (int i = 0; i < 4; i++) beat(7'h33, 3'(i), 32'hE0 + 32'(i));
        rst_i = 1'b0; cpu_rd_i = 1'b1; cpu_addr_i = 10'h123; mem_valid_i = 1'b1; mem_data_i = 32'hE4;
        #1;
        check("midrst_busy",  32'(refill_busy_o), 32'h0);
        check("midrst_ready", 32'(mem_ready_o),   32'h0);
        check("midrst_wr",    32'(ram_wr_o),      32'h0);
        check("midrst_grant", 32'(cpu_grant_o),   32'h0);
        check("midrst_addr",  32'(ram_addr_o),    32'h123);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        accept(7'h7F);
        for (int i = 0; i < 8; i++) beat(7'h7F, 3'(i), 32'hD0 + 32'(i));
        done_cycle(1'b0, 7'h00);

        // ---- request held high through DONE ----
        accept(7'h01);
        for (int i = 0; i < 8; i++) begin
            push_ev(1'b1, 1'b0, 1'b0, {7'h01, 3'(i)}, 32'hF0 + 32'(i));
            step(1'b0, 10'h0, 1'b1, 7'h01, 1'b1, 32'hF0 + 32'(i), 1'b1, "held_beat");
        end
        done_cycle(1'b1, 7'h02);
        step(1'b0, 10'h0, 1'b1, 7'h02, 1'b0, 32'h0, 1'b0, "held_idle");
        for (int i = 0; i < 8; i++) beat(7'h02, 3'(i), 32'h90 + 32'(i));
        done_cycle(1'b0, 7'h00);

        step(1'b0, 10'h0, 1'b0, 7'h0, 1'b0, 32'h0, 1'b0, "tail");
        check("events_outstanding", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
